prio_enco_pipe: RTL and testbench

- Parametrised, pipelined successor to the 8:3 encoder/decoder pair.
- Accepts an N-bit request vector over a valid/ready handshake and returns the winning index, plus a decoded one-hot loopback of that index, a no-request flag and a population count.
- Two priority modes:
  - fixed: highest index wins, matching classic encoder behaviour.
  - round-robin: a rotating pointer advances past the last winner.
- Sits between a request source and a consumer; the one-hot output lets the bench check encode/decode consistency in one DUT.

---
 rtl/prio_enco_pipe_if.sv | 35 +++
 rtl/prio_enco_pipe.sv | 109 ++++++++++
 tb/tb_prio_enco_pipe.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prio_enco_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enco_pipe_if
//  Brief    : Request/result bundle for the pipelined priority encoder.
//             The slave modport is the encoder; the master modport is the
//             request source / result consumer pair.
//  Revision : 1.0 - initial release
// ============================================================================
interface prio_enco_pipe_if #(
  parameter int N = 8
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     out_onehot;
  logic             out_none;
  logic [IDX_W:0]   out_cnt;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_none, out_cnt
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_none, out_cnt
  );
endinterface
`default_nettype wire

// File: rtl/prio_enco_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enco_pipe
//  Brief    : One-stage pipelined N-input priority encoder with fixed
//             (highest index wins) and round-robin arbitration, a one-hot
//             decode of the registered winner, a no-request flag and a
//             popcount of the accepted request vector.
//  Revision : 1.0 - initial release
// ============================================================================
module prio_enco_pipe #(
  parameter int N     = 8,   // number of requests, power of two, >= 2
  parameter int RR_EN = 1    // 0 = mode input ignored, fixed priority only
) (
  input  wire logic        clk,
  input  wire logic        rst,
  prio_enco_pipe_if.slave  bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Pointer reset value N-1 makes the very first round-robin search start at 0.
  localparam logic [IDX_W-1:0] c_ptr_init = '1;

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic             r_none;
  logic             r_dec_en;
  logic [IDX_W:0]   r_cnt;

  logic             w_rr;
  logic             w_any;
  logic             w_accept;
  logic [IDX_W-1:0] w_fix_idx;
  logic [IDX_W-1:0] w_rr_idx;
  logic [IDX_W-1:0] w_win;
  logic [IDX_W:0]   w_cnt;

  // Effective arbitration mode: round-robin only when the build allows it.
  generate
    if (RR_EN != 0) begin : g_rr_mode
      assign w_rr = bus.mode;
    end else begin : g_fixed_mode
      assign w_rr = 1'b0;
    end
  endgenerate

  assign w_any        = |bus.in_data;
  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Fixed priority: scanning upward, the last set bit seen is the highest one.
  always_comb begin
    w_fix_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.in_data[k]) w_fix_idx = IDX_W'(k);
    end
  end

  // Round-robin: scan offsets from N down to 1 so the smallest offset past the
  // pointer is written last and wins; offset N wraps to the pointer itself,
  // which therefore has the lowest priority.
  always_comb begin
    w_rr_idx = '0;
    for (int off = N; off >= 1; off--) begin
      if (bus.in_data[r_ptr + IDX_W'(off)]) w_rr_idx = r_ptr + IDX_W'(off);
    end
  end

  // Full-width popcount of the request vector, 0..N, no saturation.
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < N; k++) begin
      w_cnt = w_cnt + (IDX_W+1)'(bus.in_data[k]);
    end
  end

  assign w_win = w_rr ? w_rr_idx : w_fix_idx;

  // Result register, output handshake and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_none   <= 1'b0;
      r_dec_en <= 1'b0;
      r_cnt    <= '0;
      r_ptr    <= c_ptr_init;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_idx    <= w_any ? w_win : '0;
      r_none   <= !w_any;
      r_dec_en <= w_any;
      r_cnt    <= w_cnt;
      if (w_rr && w_any) r_ptr <= w_win;
    end else if (bus.out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.out_idx    = r_idx;
  assign bus.out_none   = r_none;
  assign bus.out_cnt    = r_cnt;
  // Decode of the registered index; suppressed after reset and for empty vectors.
  assign bus.out_onehot = r_dec_en ? ({{(N-1){1'b0}}, 1'b1} << r_idx) : '0;

endmodule
`default_nettype wire

// File: tb/tb_prio_enco_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prio_enco_pipe
//  Brief    : Self-checking bench for prio_enco_pipe. Four instances
//             (N=8, N=4, N=16 with round-robin, N=8 fixed-only) run against
//             a behavioural reference; directed literal checks on the N=8 one.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prio_enco_pipe;

  localparam int ND = 4;
  localparam int NS  [ND] = '{8, 4, 16, 8};
  localparam bit RRS [ND] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Bench-side stimulus, one slot per instance (data is 16 bits wide, masked per N).
  logic        vld  [ND];
  logic [15:0] dat  [ND];
  logic        md   [ND];
  logic        ordy [ND];

  // Instance outputs widened to a common shape.
  logic        o_valid [ND];
  logic        o_rdy   [ND];
  logic        o_none  [ND];
  logic [4:0]  o_idx   [ND];
  logic [4:0]  o_cnt   [ND];
  logic [15:0] o_oh    [ND];

  prio_enco_pipe_if #(.N(8))  bus0 ();
  prio_enco_pipe_if #(.N(4))  bus1 ();
  prio_enco_pipe_if #(.N(16)) bus2 ();
  prio_enco_pipe_if #(.N(8))  bus3 ();

  prio_enco_pipe #(.N(8),  .RR_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  prio_enco_pipe #(.N(4),  .RR_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  prio_enco_pipe #(.N(16), .RR_EN(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  prio_enco_pipe #(.N(8),  .RR_EN(0)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

`define TB_BIND(B, D, W) \
  assign B.in_valid  = vld[D]; \
  assign B.in_data   = dat[D][W-1:0]; \
  assign B.mode      = md[D]; \
  assign B.out_ready = ordy[D]; \
  assign o_valid[D]  = B.out_valid; \
  assign o_rdy[D]    = B.in_ready; \
  assign o_none[D]   = B.out_none; \
  assign o_idx[D]    = 5'(B.out_idx); \
  assign o_cnt[D]    = 5'(B.out_cnt); \
  assign o_oh[D]     = 16'(B.out_onehot);

  `TB_BIND(bus0, 0, 8)
  `TB_BIND(bus1, 1, 4)
  `TB_BIND(bus2, 2, 16)
  `TB_BIND(bus3, 3, 8)

`undef TB_BIND

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference state: one expected result slot per instance plus its pointer.
  logic exp_full  [ND];
  int   exp_idx   [ND];
  int   exp_cnt   [ND];
  logic exp_none  [ND];
  int   m_ptr     [ND];
  logic m_clean   [ND];

  // Winner from the arbitration rules, by plain arithmetic on indices.
  function automatic int enc(input logic [15:0] data, input bit rr, input int ptr, input int n);
    int idx = 0;
    bit found = 1'b0;
    if (rr) begin
      for (int off = 1; off <= n; off++) begin
        int j;
        j = (ptr + off) % n;
        if (!found && data[j]) begin idx = j; found = 1'b1; end
      end
    end else begin
      for (int k = n - 1; k >= 0; k--) begin
        if (!found && data[k]) begin idx = k; found = 1'b1; end
      end
    end
    return idx;
  endfunction

  function automatic int popc(input logic [15:0] data, input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(data[k]);
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference update on every rising edge from the stimulus actually applied.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        exp_full[d] <= 1'b0;
        m_ptr[d]    <= NS[d] - 1;
        m_clean[d]  <= 1'b1;
      end else if (vld[d] && (!exp_full[d] || ordy[d])) begin
        exp_full[d] <= 1'b1;
        m_clean[d]  <= 1'b0;
        exp_cnt[d]  <= popc(dat[d], NS[d]);
        exp_none[d] <= (popc(dat[d], NS[d]) == 0);
        exp_idx[d]  <= enc(dat[d], md[d] && RRS[d], m_ptr[d], NS[d]);
        if (md[d] && RRS[d] && popc(dat[d], NS[d]) != 0)
          m_ptr[d] <= enc(dat[d], 1'b1, m_ptr[d], NS[d]);
      end else if (ordy[d]) begin
        exp_full[d] <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of all instances against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        check($sformatf("d%0d out_valid", d), 32'(o_valid[d]), 32'(exp_full[d]));
        check($sformatf("d%0d in_ready", d), 32'(o_rdy[d]), 32'(!exp_full[d] || ordy[d]));
        if (exp_full[d]) begin
          check($sformatf("d%0d out_idx", d), 32'(o_idx[d]), 32'(exp_idx[d]));
          check($sformatf("d%0d out_cnt", d), 32'(o_cnt[d]), 32'(exp_cnt[d]));
          check($sformatf("d%0d out_none", d), 32'(o_none[d]), 32'(exp_none[d]));
          check($sformatf("d%0d out_onehot", d), 32'(o_oh[d]),
                exp_none[d] ? 32'd0 : (32'd1 << exp_idx[d]));
        end else if (m_clean[d]) begin
          check($sformatf("d%0d rst idx", d), 32'(o_idx[d]), 32'd0);
          check($sformatf("d%0d rst onehot", d), 32'(o_oh[d]), 32'd0);
          check($sformatf("d%0d rst none", d), 32'(o_none[d]), 32'd0);
          check($sformatf("d%0d rst cnt", d), 32'(o_cnt[d]), 32'd0);
        end
      end
    end
  end

  // Drive instance 0 and advance one clock; outputs are sampled #1 after the edge.
  task automatic apply(input logic v, input logic [15:0] d, input logic m, input logic r);
    vld[0] = v; dat[0] = d; md[0] = m; ordy[0] = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string name, input int idx, input int oh, input int cnt, input int none);
    check({name, " valid"},  32'(o_valid[0]), 32'd1);
    check({name, " idx"},    32'(o_idx[0]),   32'(idx));
    check({name, " onehot"}, 32'(o_oh[0]),    32'(oh));
    check({name, " cnt"},    32'(o_cnt[0]),   32'(cnt));
    check({name, " none"},   32'(o_none[0]),  32'(none));
  endtask

  int r;

  initial begin
    for (int d = 0; d < ND; d++) begin
      vld[d] = 1'b0; dat[d] = '0; md[d] = 1'b0; ordy[d] = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    // Reset state
    check("reset valid",  32'(o_valid[0]), 32'd0);
    check("reset idx",    32'(o_idx[0]),   32'd0);
    check("reset onehot", 32'(o_oh[0]),    32'd0);
    check("reset none",   32'(o_none[0]),  32'd0);
    check("reset cnt",    32'(o_cnt[0]),   32'd0);
    rst = 1'b0;

    // Fixed priority, zero vector, all ones
    apply(1'b1, 16'h002C, 1'b0, 1'b1); chk_res("fixed 2C", 5, 'h20, 3, 0);
    apply(1'b1, 16'h0000, 1'b0, 1'b1); chk_res("zero",     0, 'h00, 0, 1);
    apply(1'b1, 16'h00FF, 1'b0, 1'b1); chk_res("fixed FF", 7, 'h80, 8, 0);

    // Round-robin after a fresh reset
    rst = 1'b1; apply(1'b0, 16'h0000, 1'b0, 1'b1); rst = 1'b0;
    apply(1'b1, 16'h00FF, 1'b1, 1'b1); chk_res("rr #1", 0, 'h01, 8, 0);
    apply(1'b1, 16'h00FF, 1'b1, 1'b1); chk_res("rr #2", 1, 'h02, 8, 0);
    apply(1'b1, 16'h00FF, 1'b1, 1'b1); chk_res("rr #3", 2, 'h04, 8, 0);
    apply(1'b1, 16'h0003, 1'b1, 1'b1); chk_res("rr wrap", 0, 'h01, 2, 0);
    apply(1'b1, 16'h0081, 1'b0, 1'b1); chk_res("fixed 81", 7, 'h80, 2, 0);
    apply(1'b1, 16'h00FF, 1'b1, 1'b1); chk_res("rr ptr held", 1, 'h02, 8, 0);

    // Backpressure: winner 6 held for three stalled cycles
    apply(1'b1, 16'h0040, 1'b1, 1'b1); chk_res("bp load", 6, 'h40, 1, 0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 16'h0001, 1'b1, 1'b0);
      chk_res($sformatf("bp stall%0d", i), 6, 'h40, 1, 0);
      check($sformatf("bp stall%0d in_ready", i), 32'(o_rdy[0]), 32'd0);
    end
    apply(1'b1, 16'h0001, 1'b1, 1'b1); chk_res("bp release", 0, 'h01, 1, 0);

    // Reset while a result is stalled
    apply(1'b1, 16'h0008, 1'b0, 1'b1); chk_res("pre-rst", 3, 'h08, 1, 0);
    apply(1'b0, 16'h0000, 1'b0, 1'b0); chk_res("pre-rst hold", 3, 'h08, 1, 0);
    rst = 1'b1; apply(1'b0, 16'h0000, 1'b0, 1'b0);
    check("mid-rst valid",  32'(o_valid[0]), 32'd0);
    check("mid-rst idx",    32'(o_idx[0]),   32'd0);
    check("mid-rst onehot", 32'(o_oh[0]),    32'd0);
    check("mid-rst cnt",    32'(o_cnt[0]),   32'd0);
    rst = 1'b0;
    apply(1'b1, 16'h00FF, 1'b1, 1'b1); chk_res("post-rst rr", 0, 'h01, 8, 0);
    apply(1'b0, 16'h0000, 1'b0, 1'b1);
    check("drain valid", 32'(o_valid[0]), 32'd0);

    // Random traffic on all instances with backpressure and rare resets
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < ND; d++) begin
        vld[d] = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        dat[d] = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
        md[d]   = 1'($urandom_range(0, 1));
        ordy[d] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // Full-rate streaming: every cycle must accept and present a result
    for (int c = 0; c < 200; c++) begin
      for (int d = 0; d < ND; d++) begin
        vld[d] = 1'b1; ordy[d] = 1'b1;
        dat[d] = 16'($urandom); md[d] = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        check($sformatf("d%0d stream valid", d), 32'(o_valid[d]), 32'd1);
        check($sformatf("d%0d stream ready", d), 32'(o_rdy[d]), 32'd1);
      end
    end

    for (int d = 0; d < ND; d++) vld[d] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
